tpu_result_drain: RTL and testbench

- Downstream of the TPU top: captures the three result-SRAM write streams (a, b, c) that the TPU emits.
- Buffers each written row, tagged with its set and address, in a FIFO.
- Streams the rows to the host/DMA side over a valid/ready interface.
- Marks the final row after tpu_done and reports drop and protocol errors.

---
 rtl/tpu_drain_pkg.sv | 24 ++
 rtl/drain_fifo.sv | 57 +++++
 rtl/tpu_result_drain.sv | 159 +++++++++++++++
 tb/tb_tpu_result_drain.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_drain_pkg.sv
// Shared types and helpers for the TPU result drain.
// State codes, result-set tags and FIFO entry sizing.
package tpu_drain_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FLUSH   = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [1:0] SET_A = 2'd0;
    localparam logic [1:0] SET_B = 2'd1;
    localparam logic [1:0] SET_C = 2'd2;

    function automatic int entry_width(
        input int array_size,
        input int data_width,
        input int addr_width
    );
        return array_size * data_width + 2 + addr_width;
    endfunction

endpackage

// File: rtl/drain_fifo.sv
// Synchronous FIFO with register-array storage.
// The head entry is read straight from flops, so pop_data is registered.
module drain_fifo #(
    parameter int WIDTH = 136,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PtrW = $clog2(DEPTH);
    localparam int CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_q;
    logic [PtrW-1:0]  rd_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CntW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_q];
    assign count    = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_data;
                wr_q        <= wr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/tpu_result_drain.sv
// Captures TPU result-SRAM writes, queues them tagged with set/address,
// and streams them out with end-of-run marking and error flags.
module tpu_result_drain
    import tpu_drain_pkg::*;
#(
    parameter int ARRAY_SIZE        = 8,
    parameter int OUTPUT_DATA_WIDTH = 16,
    parameter int FIFO_DEPTH        = 8,
    parameter int ADDR_WIDTH        = 6
) (
    input  logic                                    clk,
    input  logic                                    srstn,
    input  logic                                    sram_write_enable_a0,
    input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_wdata_a,
    input  logic [ADDR_WIDTH-1:0]                   sram_waddr_a,
    input  logic                                    sram_write_enable_b0,
    input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_wdata_b,
    input  logic [ADDR_WIDTH-1:0]                   sram_waddr_b,
    input  logic                                    sram_write_enable_c0,
    input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_wdata_c,
    input  logic [ADDR_WIDTH-1:0]                   sram_waddr_c,
    input  logic                                    tpu_done,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] out_data,
    output logic [1:0]                              out_set,
    output logic [ADDR_WIDTH-1:0]                   out_addr,
    output logic                                    out_last,
    output logic                                    drain_done,
    output logic                                    overflow,
    output logic                                    protocol_err,
    output logic [$clog2(FIFO_DEPTH):0]             fifo_count
);

    localparam int RowW   = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
    localparam int EntryW = entry_width(ARRAY_SIZE, OUTPUT_DATA_WIDTH, ADDR_WIDTH);
    localparam int CntW   = $clog2(FIFO_DEPTH) + 1;

    state_e state_q, state_d;
    logic   overflow_q, overflow_d;
    logic   perr_q, perr_d;

    logic                  sel_valid;
    logic [1:0]            sel_set;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [RowW-1:0]       sel_data;
    logic                  multi;

    logic              push_allow;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              drained;
    logic [EntryW-1:0] pop_data;
    logic [CntW-1:0]   count;

    always_comb begin
        sel_valid = 1'b1;
        sel_set   = SET_A;
        sel_addr  = '0;
        sel_data  = '0;
        priority case (1'b1)
            sram_write_enable_a0: begin
                sel_addr = sram_waddr_a;
                sel_data = sram_wdata_a;
            end
            sram_write_enable_b0: begin
                sel_set  = SET_B;
                sel_addr = sram_waddr_b;
                sel_data = sram_wdata_b;
            end
            sram_write_enable_c0: begin
                sel_set  = SET_C;
                sel_addr = sram_waddr_c;
                sel_data = sram_wdata_c;
            end
            default: sel_valid = 1'b0;
        endcase
    end

    assign multi = (sram_write_enable_a0 && sram_write_enable_b0)
                || (sram_write_enable_a0 && sram_write_enable_c0)
                || (sram_write_enable_b0 && sram_write_enable_c0);

    // A full FIFO still takes a row when the head leaves in the same cycle.
    assign out_valid  = !empty;
    assign pop        = out_valid && out_ready;
    assign push_allow = sel_valid && (state_q != FLUSH);
    assign push       = push_allow && (!full || pop);
    assign drained    = empty || (count == CntW'(1) && pop);

    drain_fifo #(
        .WIDTH (EntryW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (srstn),
        .push      (push),
        .push_data ({sel_set, sel_addr, sel_data}),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_comb begin
        state_d    = state_q;
        overflow_d = overflow_q || (push_allow && full && !pop);
        perr_d     = perr_q || multi || (sel_valid && state_q == FLUSH);
        case (state_q)
            IDLE: begin
                if (push) begin
                    state_d = tpu_done ? FLUSH : COLLECT;
                end else if (tpu_done && empty) begin
                    state_d = DONE;
                end
            end
            COLLECT: begin
                if (tpu_done) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (drained) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = push ? COLLECT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_q    <= IDLE;
            overflow_q <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
            perr_q     <= perr_d;
        end
    end

    assign out_data     = pop_data[RowW-1:0];
    assign out_addr     = pop_data[RowW +: ADDR_WIDTH];
    assign out_set      = pop_data[EntryW-1 -: 2];
    assign out_last     = (state_q == FLUSH) && out_valid
                       && (count == CntW'(1));
    assign drain_done   = (state_q == DONE);
    assign overflow     = overflow_q;
    assign protocol_err = perr_q;
    assign fifo_count   = count;

endmodule

// File: tb/tb_tpu_result_drain.sv
// Directed self-checking bench for tpu_result_drain.
// Each scenario task drives stimulus and checks outputs inline.
module tb_tpu_result_drain;

    localparam int AS = 8;
    localparam int DW = 16;
    localparam int FD = 8;
    localparam int AW = 6;
    localparam int RW = AS * DW;

    logic          clk = 1'b0;
    logic          srstn = 1'b0;
    logic          we_a, we_b, we_c;
    logic [RW-1:0] wd_a, wd_b, wd_c;
    logic [AW-1:0] wa_a, wa_b, wa_c;
    logic          tpu_done;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_data;
    logic [1:0]    out_set;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          drain_done;
    logic          overflow;
    logic          protocol_err;
    logic [3:0]    fifo_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tpu_result_drain #(
        .ARRAY_SIZE        (AS),
        .OUTPUT_DATA_WIDTH (DW),
        .FIFO_DEPTH        (FD),
        .ADDR_WIDTH        (AW)
    ) dut (
        .clk                  (clk),
        .srstn                (srstn),
        .sram_write_enable_a0 (we_a),
        .sram_wdata_a         (wd_a),
        .sram_waddr_a         (wa_a),
        .sram_write_enable_b0 (we_b),
        .sram_wdata_b         (wd_b),
        .sram_waddr_b         (wa_b),
        .sram_write_enable_c0 (we_c),
        .sram_wdata_c         (wd_c),
        .sram_waddr_c         (wa_c),
        .tpu_done             (tpu_done),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .out_data             (out_data),
        .out_set              (out_set),
        .out_addr             (out_addr),
        .out_last             (out_last),
        .drain_done           (drain_done),
        .overflow             (overflow),
        .protocol_err         (protocol_err),
        .fifo_count           (fifo_count)
    );

    function automatic logic [RW-1:0] row(input logic [15:0] v);
        return {AS{v}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        we_a = 0; we_b = 0; we_c = 0;
        wd_a = '0; wd_b = '0; wd_c = '0;
        wa_a = '0; wa_b = '0; wa_c = '0;
        tpu_done = 0;
    endtask

    task automatic do_reset();
        clear_in();
        out_ready = 0;
        srstn = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        srstn = 1;
        tick();
    endtask

    task automatic test_reset();
        clear_in();
        out_ready = 0;
        srstn = 0;
        #2;
        checks++;
        if ({out_valid, out_set, out_addr, out_last, drain_done, overflow,
             protocol_err, fifo_count} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got %0h want 0",
                     {out_valid, out_set, out_addr, out_last, drain_done,
                      overflow, protocol_err, fifo_count});
        end
        checks++;
        if (out_data !== '0) begin
            errors++;
            $display("FAIL reset_data got %0h want 0", out_data);
        end
        @(negedge clk);
        srstn = 1;
        tick();
        tick();
        checks++;
        if ({out_valid, drain_done, fifo_count} !== '0) begin
            errors++;
            $display("FAIL reset_release got %0h want 0",
                     {out_valid, drain_done, fifo_count});
        end
    endtask

    task automatic test_single_row();
        int pulses;
        int pulse_at;
        int lasts;
        do_reset();
        out_ready = 1;
        we_a = 1; wa_a = 6'd5; wd_a = row(16'h0001);
        tick();
        clear_in();
        checks++;
        if ({out_valid, out_set, out_addr, out_last} !== {1'b1, 2'd0, 6'd5, 1'b0}) begin
            errors++;
            $display("FAIL single_hdr got v%0b s%0d a%0d l%0b want v1 s0 a5 l0",
                     out_valid, out_set, out_addr, out_last);
        end
        checks++;
        if (out_data !== row(16'h0001)) begin
            errors++;
            $display("FAIL single_data got %0h want %0h", out_data, row(16'h0001));
        end
        tick();
        tick();
        tpu_done = 1;
        pulses = 0;
        pulse_at = -1;
        lasts = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            tpu_done = 0;
            if (drain_done) begin
                pulses++;
                if (pulse_at < 0) pulse_at = i;
            end
            if (out_last) lasts++;
        end
        checks++;
        if (pulses !== 1 || pulse_at !== 1) begin
            errors++;
            $display("FAIL single_done got pulses %0d at %0d want 1 at 1",
                     pulses, pulse_at);
        end
        checks++;
        if (lasts !== 0) begin
            errors++;
            $display("FAIL single_nolast got %0d want 0", lasts);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        we_a = 1; wa_a = 6'd0; wd_a = row(16'h1111);
        tick();
        clear_in();
        we_b = 1; wa_b = 6'd1; wd_b = row(16'h2222);
        tick();
        clear_in();
        we_c = 1; wa_c = 6'd2; wd_c = row(16'h3333);
        tick();
        clear_in();
        tpu_done = 1;
        tick();
        tpu_done = 0;
        checks++;
        if (fifo_count !== 4'd3) begin
            errors++;
            $display("FAIL bp_count got %0d want 3", fifo_count);
        end
        tick();
        tick();
        checks++;
        if ({out_valid, out_set, out_addr, out_last} !== {1'b1, 2'd0, 6'd0, 1'b0}
            || out_data !== row(16'h1111)) begin
            errors++;
            $display("FAIL bp_stable got v%0b s%0d a%0d l%0b d%0h want v1 s0 a0 l0",
                     out_valid, out_set, out_addr, out_last, out_data);
        end
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_set !== 2'(i) || out_addr !== 6'(i)
                || out_last !== (i == 2) || drain_done !== 1'b0
                || out_data !== row(16'((i + 1) * 16'h1111))) begin
                errors++;
                $display("FAIL bp_row%0d got v%0b s%0d a%0d l%0b dd%0b want s%0d a%0d l%0b",
                         i, out_valid, out_set, out_addr, out_last, drain_done,
                         i, i, (i == 2));
            end
            tick();
        end
        checks++;
        if ({drain_done, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_done got dd%0b v%0b want dd1 v0", drain_done, out_valid);
        end
        tick();
        checks++;
        if (drain_done !== 1'b0) begin
            errors++;
            $display("FAIL bp_done_pulse got %0b want 0", drain_done);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < FD + 2; i++) begin
            we_a = 1; wa_a = 6'(i); wd_a = row(16'(i));
            tick();
            if (i == FD - 1) begin
                checks++;
                if ({fifo_count, overflow} !== {4'd8, 1'b0}) begin
                    errors++;
                    $display("FAIL ovf_fill got c%0d o%0b want c8 o0",
                             fifo_count, overflow);
                end
            end
        end
        clear_in();
        checks++;
        if ({fifo_count, overflow} !== {4'd8, 1'b1}) begin
            errors++;
            $display("FAIL ovf_flag got c%0d o%0b want c8 o1", fifo_count, overflow);
        end
        tpu_done = 1;
        tick();
        tpu_done = 0;
        out_ready = 1;
        for (int i = 0; i < FD; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_addr !== 6'(i) || out_last !== (i == FD - 1)) begin
                errors++;
                $display("FAIL ovf_row%0d got v%0b a%0d l%0b want v1 a%0d l%0b",
                         i, out_valid, out_addr, out_last, i, (i == FD - 1));
            end
            tick();
        end
        checks++;
        if ({drain_done, out_valid, fifo_count} !== {1'b1, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL ovf_end got dd%0b v%0b c%0d want dd1 v0 c0",
                     drain_done, out_valid, fifo_count);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < FD; i++) begin
            we_a = 1; wa_a = 6'(i); wd_a = row(16'(i));
            tick();
        end
        clear_in();
        we_b = 1; wa_b = 6'd8; wd_b = row(16'h0008);
        out_ready = 1;
        tick();
        clear_in();
        checks++;
        if ({fifo_count, overflow, out_addr} !== {4'd8, 1'b0, 6'd1}) begin
            errors++;
            $display("FAIL fpp_hold got c%0d o%0b a%0d want c8 o0 a1",
                     fifo_count, overflow, out_addr);
        end
        for (int i = 0; i < FD; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_addr !== 6'(i + 1)
                || out_set !== ((i == FD - 1) ? 2'd1 : 2'd0)) begin
                errors++;
                $display("FAIL fpp_row%0d got v%0b a%0d s%0d want a%0d",
                         i, out_valid, out_addr, out_set, i + 1);
            end
            tick();
        end
        checks++;
        if ({fifo_count, out_valid, overflow} !== '0) begin
            errors++;
            $display("FAIL fpp_end got c%0d v%0b o%0b want 0",
                     fifo_count, out_valid, overflow);
        end
    endtask

    task automatic test_collision();
        do_reset();
        we_a = 1; wa_a = 6'd3; wd_a = row(16'h00AA);
        we_c = 1; wa_c = 6'd4; wd_c = row(16'h00CC);
        tick();
        clear_in();
        checks++;
        if ({fifo_count, protocol_err, out_set, out_addr} !== {4'd1, 1'b1, 2'd0, 6'd3}
            || out_data !== row(16'h00AA)) begin
            errors++;
            $display("FAIL col_push got c%0d p%0b s%0d a%0d want c1 p1 s0 a3",
                     fifo_count, protocol_err, out_set, out_addr);
        end
        tpu_done = 1;
        tick();
        tpu_done = 0;
        we_b = 1; wa_b = 6'd9; wd_b = row(16'h00BB);
        tick();
        clear_in();
        checks++;
        if ({fifo_count, protocol_err, out_last} !== {4'd1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL col_flush got c%0d p%0b l%0b want c1 p1 l1",
                     fifo_count, protocol_err, out_last);
        end
        out_ready = 1;
        tick();
        checks++;
        if ({drain_done, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL col_done got dd%0b v%0b want dd1 v0", drain_done, out_valid);
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        we_a = 1; we_b = 1; wa_a = 6'd0; wd_a = row(16'h0100);
        tick();
        clear_in();
        for (int i = 1; i < 4; i++) begin
            we_a = 1; wa_a = 6'(i); wd_a = row(16'(16'h0100 + i));
            tick();
        end
        clear_in();
        checks++;
        if ({out_valid, fifo_count, protocol_err} !== {1'b1, 4'd4, 1'b1}) begin
            errors++;
            $display("FAIL rmd_pre got v%0b c%0d p%0b want v1 c4 p1",
                     out_valid, fifo_count, protocol_err);
        end
        #2;
        srstn = 0;
        #1;
        checks++;
        if ({out_valid, out_set, out_addr, out_last, drain_done, overflow,
             protocol_err, fifo_count} !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL rmd_async got v%0b c%0d p%0b d%0h want 0",
                     out_valid, fifo_count, protocol_err, out_data);
        end
        @(posedge clk);
        @(negedge clk);
        srstn = 1;
        tick();
        checks++;
        if ({out_valid, fifo_count, overflow, protocol_err, drain_done} !== '0) begin
            errors++;
            $display("FAIL rmd_post got v%0b c%0d o%0b p%0b want 0",
                     out_valid, fifo_count, overflow, protocol_err);
        end
        tpu_done = 1;
        tick();
        tpu_done = 0;
        checks++;
        if (drain_done !== 1'b1) begin
            errors++;
            $display("FAIL rmd_idle got dd%0b want 1", drain_done);
        end
    endtask

    initial begin
        clear_in();
        out_ready = 0;
        test_reset();
        test_single_row();
        test_backpressure();
        test_overflow();
        test_full_push_pop();
        test_collision();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
